// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one RIB slave port among NUM_M masters.
// The winner's request is latched for the whole transfer; the response is registered.
module rib_arbiter #(
    parameter int               NUM_M     = 4,
    parameter int               AW        = 32,
    parameter int               DW        = 32,
    parameter int               TIMEOUT   = 255,
    parameter logic [NUM_M-1:0] HOLD_MASK = NUM_M'(4'b0011)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_wdata_i,
    output logic [DW-1:0]       m_rdata_o,
    output logic [NUM_M-1:0]    m_ready_o,
    output logic [NUM_M-1:0]    grant_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_wdata_o,
    input  logic [DW-1:0]       s_rdata_i,
    input  logic                s_ready_i,
    output logic                err_o,
    output logic                hold_flag_o
);
    localparam int IW = $clog2(NUM_M);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, last_q, win_idx;
    logic              win_found;
    logic [NUM_M-1:0]  arb_req, grant_q, ready_q;
    logic              we_q, err_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q, rdata_q;
    logic [CW-1:0]     cnt_q, cnt_inc;
    logic              tmo, load, done;

    // First set bit scanning upward from last+1, wrapping at NUM_M.
    function automatic logic [IW:0] rr_pick(input logic [NUM_M-1:0] req,
                                            input logic [IW-1:0]    last);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int i = NUM_M; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_M;
            if (req[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    assign cnt_inc = cnt_q + 1'b1;
    assign tmo     = (TIMEOUT != 0) && !s_ready_i && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        // The finishing owner still holds its request during RESP, so mask it out.
        arb_req = (state_q == RESP) ? (m_req_i & ~grant_q) : m_req_i;
        {win_found, win_idx} = rr_pick(arb_req, last_q);
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ready_i || tmo) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= '0;
            last_q  <= IW'(NUM_M - 1);
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= '0;
            err_q   <= 1'b0;
            if (load) begin
                owner_q <= win_idx;
                grant_q <= NUM_M'(1) << win_idx;
                we_q    <= m_we_i[win_idx];
                addr_q  <= m_addr_i[int'(win_idx)*AW +: AW];
                wdata_q <= m_wdata_i[int'(win_idx)*DW +: DW];
                cnt_q   <= '0;
            end else if (state_q == RESP) begin
                grant_q <= '0;
            end
            if (state_q == BUSY) begin
                if (done) begin
                    ready_q <= grant_q;
                    err_q   <= tmo;
                    rdata_q <= s_ready_i ? s_rdata_i : '0;
                    last_q  <= owner_q;
                end else begin
                    cnt_q   <= cnt_inc;
                end
            end
        end
    end

    assign s_req_o     = (state_q == BUSY);
    assign s_we_o      = we_q;
    assign s_addr_o    = addr_q;
    assign s_wdata_o   = wdata_q;
    assign grant_o     = grant_q;
    assign m_ready_o   = ready_q;
    assign m_rdata_o   = rdata_q;
    assign err_o       = err_q;
    assign hold_flag_o = |(m_req_i & HOLD_MASK & ~((state_q != IDLE) ? grant_q : '0));

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: latency, round-robin order, latching, timeout, hold flag, reset.
module tb_rib_arbiter;
    localparam int NUM_M   = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [NUM_M-1:0]    m_req_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M*AW-1:0] m_addr_i;
    logic [NUM_M*DW-1:0] m_wdata_i;
    logic [DW-1:0]       m_rdata_o;
    logic [NUM_M-1:0]    m_ready_o;
    logic [NUM_M-1:0]    grant_o;
    logic                s_req_o;
    logic                s_we_o;
    logic [AW-1:0]       s_addr_o;
    logic [DW-1:0]       s_wdata_o;
    logic [DW-1:0]       s_rdata_i;
    logic                s_ready_i;
    logic                err_o;
    logic                hold_flag_o;

    int n_chk = 0;
    int n_err = 0;

    rib_arbiter #(
        .NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .HOLD_MASK(4'b0011)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_rdata_o(m_rdata_o), .m_ready_o(m_ready_o), .grant_o(grant_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
        .err_o(err_o), .hold_flag_o(hold_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        m_req_i   = '0;
        m_we_i    = '0;
        s_ready_i = 1'b0;
        tick();
        tick();
        check("rst_grant", grant_o, 0);
        check("rst_s_req", s_req_o, 0);
        check("rst_ready", m_ready_o, 0);
        check("rst_rdata", m_rdata_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", s_addr_o, 0);
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_addr_i  = '0;
        m_wdata_i = '0;
        s_rdata_i = '0;
        for (int k = 0; k < NUM_M; k++) begin
            m_addr_i[k*AW +: AW]  = 32'h3000_0000 + k * 4;
            m_wdata_i[k*DW +: DW] = 32'h0D00_0000 + k;
        end
        do_reset();

        // single read, zero-wait slave
        m_req_i = 4'b0001;
        m_addr_i[0 +: AW] = 32'h1000_0004;
        s_ready_i = 1'b1;
        s_rdata_i = 32'hA5A5_0001;
        #1;
        check("t1_c0_sreq", s_req_o, 0);
        check("t1_c0_hold", hold_flag_o, 1);
        tick();
        check("t1_c1_sreq", s_req_o, 1);
        check("t1_c1_addr", s_addr_o, 32'h1000_0004);
        check("t1_c1_grant", grant_o, 4'b0001);
        m_req_i = 4'b0000;
        tick();
        check("t1_c2_ready", m_ready_o, 4'b0001);
        check("t1_c2_rdata", m_rdata_o, 32'hA5A5_0001);
        check("t1_c2_sreq", s_req_o, 0);
        tick();
        check("t1_c3_grant", grant_o, 0);
        check("t1_c3_ready", m_ready_o, 0);
        check("t1_c3_rdata_hold", m_rdata_o, 32'hA5A5_0001);

        // all masters requesting: round-robin 0,1,2,3,0
        do_reset();
        m_addr_i[0 +: AW] = 32'h3000_0000;
        m_req_i   = 4'b1111;
        s_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_rdata_i = 32'hB000_0000 + k;
            tick();
            check("t2_busy_grant", grant_o, 64'(1 << (k % 4)));
            check("t2_busy_sreq", s_req_o, 1);
            check("t2_busy_noready", m_ready_o, 0);
            check("t2_busy_addr", s_addr_o, 32'h3000_0000 + (k % 4) * 4);
            tick();
            check("t2_resp_ready", m_ready_o, 64'(1 << (k % 4)));
            check("t2_resp_rdata", m_rdata_o, 32'hB000_0000 + k);
            check("t2_resp_sreq", s_req_o, 0);
            if (k == 4) m_req_i = 4'b0000;
        end
        tick();
        check("t2_idle_grant", grant_o, 0);
        check("t2_idle_ready", m_ready_o, 0);

        // one master held: RESP -> IDLE -> BUSY
        m_req_i = 4'b0001;
        tick();
        check("t2s_busy", s_req_o, 1);
        tick();
        check("t2s_resp_sreq", s_req_o, 0);
        check("t2s_resp_ready", m_ready_o, 4'b0001);
        tick();
        check("t2s_idle_sreq", s_req_o, 0);
        check("t2s_idle_grant", grant_o, 0);
        tick();
        check("t2s_rebusy_sreq", s_req_o, 1);
        check("t2s_rebusy_grant", grant_o, 4'b0001);
        m_req_i = 4'b0000;
        tick();
        tick();

        // master 2 write, inputs change after grant, slave waits 5 cycles
        s_ready_i = 1'b0;
        m_req_i   = 4'b0100;
        m_we_i    = 4'b0100;
        m_addr_i[2*AW +: AW]  = 32'h2000_0000;
        m_wdata_i[2*DW +: DW] = 32'hDEAD_0002;
        tick();
        check("t3_we", s_we_o, 1);
        m_req_i = 4'b0000;
        m_we_i  = 4'b0000;
        m_addr_i[2*AW +: AW]  = 32'hFFFF_FFF0;
        m_wdata_i[2*DW +: DW] = 32'h1111_1111;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check("t3_addr", s_addr_o, 32'h2000_0000);
            check("t3_wdata", s_wdata_o, 32'hDEAD_0002);
            check("t3_sreq", s_req_o, 1);
            if (c == 5) begin
                s_ready_i = 1'b1;
                s_rdata_i = 32'hC0DE_0003;
            end else begin
                tick();
            end
        end
        tick();
        check("t3_ready", m_ready_o, 4'b0100);
        check("t3_err", err_o, 0);
        s_ready_i = 1'b0;
        tick();
        check("t3_idle_grant", grant_o, 0);

        // timeout abort after 8 BUSY cycles
        s_rdata_i = 32'h1234_5678;
        m_req_i   = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("t4_sreq", s_req_o, 1);
            check("t4_err_low", err_o, 0);
            if (c == 1) m_req_i = 4'b0000;
        end
        tick();
        check("t4_to_sreq", s_req_o, 0);
        check("t4_to_ready", m_ready_o, 4'b0010);
        check("t4_to_rdata", m_rdata_o, 0);
        check("t4_to_err", err_o, 1);
        tick();
        check("t4_err_pulse", err_o, 0);
        check("t4_ready_pulse", m_ready_o, 0);
        check("t4_idle_grant", grant_o, 0);

        // ready in the 8th BUSY cycle wins over the timeout
        m_req_i = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("t4b_sreq", s_req_o, 1);
            if (c == 1) m_req_i = 4'b0000;
            if (c == 8) begin
                s_ready_i = 1'b1;
                s_rdata_i = 32'h5555_0008;
            end
        end
        tick();
        check("t4b_ready", m_ready_o, 4'b0010);
        check("t4b_rdata", m_rdata_o, 32'h5555_0008);
        check("t4b_err", err_o, 0);
        s_ready_i = 1'b0;
        tick();

        // hold flag while master 0 waits behind master 3
        m_req_i = 4'b1000;
        #1;
        check("t5_hold_m3only", hold_flag_o, 0);
        tick();
        check("t5_grant3", grant_o, 4'b1000);
        m_req_i = 4'b1001;
        #1;
        check("t5_hold_wait1", hold_flag_o, 1);
        tick();
        check("t5_hold_wait2", hold_flag_o, 1);
        s_ready_i = 1'b1;
        s_rdata_i = 32'h7777_0003;
        tick();
        check("t5_resp3_ready", m_ready_o, 4'b1000);
        check("t5_resp3_hold", hold_flag_o, 1);
        m_req_i = 4'b0001;
        #1;
        check("t5_resp3_hold_m0", hold_flag_o, 1);
        tick();
        check("t5_busy0_grant", grant_o, 4'b0001);
        check("t5_busy0_hold", hold_flag_o, 0);
        tick();
        check("t5_resp0_ready", m_ready_o, 4'b0001);
        check("t5_resp0_hold", hold_flag_o, 0);
        m_req_i   = 4'b0000;
        s_ready_i = 1'b0;
        tick();

        // asynchronous reset in the third BUSY cycle
        m_req_i = 4'b0100;
        tick();
        tick();
        tick();
        check("t6_busy3_sreq", s_req_o, 1);
        rst_ni = 1'b0;
        #1;
        check("t6_async_sreq", s_req_o, 0);
        check("t6_async_grant", grant_o, 0);
        check("t6_async_ready", m_ready_o, 0);
        m_req_i = 4'b1111;
        tick();
        check("t6_rst_ready", m_ready_o, 0);
        check("t6_rst_sreq", s_req_o, 0);
        rst_ni = 1'b1;
        tick();
        check("t6_first_grant", grant_o, 4'b0001);
        check("t6_first_sreq", s_req_o, 1);
        m_req_i   = 4'b0000;
        s_ready_i = 1'b1;
        tick();
        check("t6_first_ready", m_ready_o, 4'b0001);
        s_ready_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
